// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one burst memory port between three requesters
// (0 = icache refill, 1 = dcache refill/writeback, 2 = aux pixel feeder).
// One transaction at a time: IDLE -> CMD -> WDATA|RDATA -> IDLE.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority 1 > 0 > 2;
// the default build arbitrates round-robin starting at requester 0.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int MASK_W    = DATA_W / 8,
  parameter int BURST_LEN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req_valid,
  input  logic [2:0]            req_rnw,
  input  logic [3*ADDR_W-1:0]   req_addr,
  output logic [2:0]            req_ready,
  input  logic [2:0]            wvalid,
  input  logic [3*DATA_W-1:0]   wdata,
  input  logic [3*MASK_W-1:0]   wmask,
  output logic [2:0]            wready,
  output logic [2:0]            rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_rnw,
  output logic [ADDR_W-1:0]     mem_cmd_addr,
  output logic                  mem_wdata_valid,
  input  logic                  mem_wdata_ready,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [MASK_W-1:0]     mem_wmask,
  input  logic                  mem_rdata_valid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy,
  output logic [1:0]            grant_id,
  output logic                  err_unexp_rdata
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } arbStateT;

  arbStateT             stateR;
  logic [1:0]           grantR;
  logic                 rnwR;
  logic [ADDR_W-1:0]    addrR;
  logic [CNT_W-1:0]     cntR;
  logic [2:0]           reqReadyR;
  logic                 cmdValidR;
  logic                 busyR;
  logic [1:0]           grantIdR;
  logic                 errR;
`ifndef ARB_FIXED_PRIO_EN
  logic [1:0]           lastGrantR;
`endif

  logic [1:0]           winnerS;
  logic                 winnerRnwS;
  logic [ADDR_W-1:0]    winnerAddrS;
  logic [2:0]           grantOneHotS;
  logic                 selWvalidS;
  logic [DATA_W-1:0]    selWdataS;
  logic [MASK_W-1:0]    selWmaskS;
  logic                 beatS;
  logic [CNT_W-1:0]     cntNextS;

  function automatic logic [2:0] toOneHot(input logic [1:0] id);
    logic [2:0] oh;
    case (id)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: dcache first, then icache, then aux.
  function automatic logic [1:0] pickWinner(input logic [2:0] valid);
    logic [1:0] pick;
    if (valid[1]) begin
      pick = 2'd1;
    end else if (valid[0]) begin
      pick = 2'd0;
    end else begin
      pick = 2'd2;
    end
    return pick;
  endfunction
`else
  // Round-robin: search upward from the requester after the last owner.
  function automatic logic [1:0] pickWinner(input logic [2:0] valid, input logic [1:0] last);
    logic [1:0] pick;
    case (last)
      2'd0:    pick = valid[1] ? 2'd1 : (valid[2] ? 2'd2 : 2'd0);
      2'd1:    pick = valid[2] ? 2'd2 : (valid[0] ? 2'd0 : 2'd1);
      default: pick = valid[0] ? 2'd0 : (valid[1] ? 2'd1 : 2'd2);
    endcase
    return pick;
  endfunction
`endif

  // Select the arbitration winner and its command fields.
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    winnerS = pickWinner(req_valid);
`else
    winnerS = pickWinner(req_valid, lastGrantR);
`endif
    winnerRnwS  = 1'b0;
    winnerAddrS = {ADDR_W{1'b0}};
    case (winnerS)
      2'd0:    begin winnerRnwS = req_rnw[0]; winnerAddrS = req_addr[0*ADDR_W +: ADDR_W]; end
      2'd1:    begin winnerRnwS = req_rnw[1]; winnerAddrS = req_addr[1*ADDR_W +: ADDR_W]; end
      2'd2:    begin winnerRnwS = req_rnw[2]; winnerAddrS = req_addr[2*ADDR_W +: ADDR_W]; end
      default: begin winnerRnwS = 1'b0;       winnerAddrS = {ADDR_W{1'b0}}; end
    endcase
  end

  // Pick the current owner's write-beat slice.
  always_comb begin
    grantOneHotS = toOneHot(grantR);
    selWvalidS   = 1'b0;
    selWdataS    = {DATA_W{1'b0}};
    selWmaskS    = {MASK_W{1'b0}};
    case (grantR)
      2'd0: begin
        selWvalidS = wvalid[0];
        selWdataS  = wdata[0*DATA_W +: DATA_W];
        selWmaskS  = wmask[0*MASK_W +: MASK_W];
      end
      2'd1: begin
        selWvalidS = wvalid[1];
        selWdataS  = wdata[1*DATA_W +: DATA_W];
        selWmaskS  = wmask[1*MASK_W +: MASK_W];
      end
      2'd2: begin
        selWvalidS = wvalid[2];
        selWdataS  = wdata[2*DATA_W +: DATA_W];
        selWmaskS  = wmask[2*MASK_W +: MASK_W];
      end
      default: begin
        selWvalidS = 1'b0;
        selWdataS  = {DATA_W{1'b0}};
        selWmaskS  = {MASK_W{1'b0}};
      end
    endcase
  end

  // Route write beats and read beats between memory and the owner only.
  always_comb begin
    mem_wdata_valid = 1'b0;
    mem_wdata       = {DATA_W{1'b0}};
    mem_wmask       = {MASK_W{1'b0}};
    wready          = 3'b000;
    rd_valid        = 3'b000;
    case (stateR)
      WDATA: begin
        mem_wdata_valid = selWvalidS;
        mem_wdata       = selWdataS;
        mem_wmask       = selWmaskS;
        wready          = mem_wdata_ready ? grantOneHotS : 3'b000;
      end
      RDATA: begin
        rd_valid = mem_rdata_valid ? grantOneHotS : 3'b000;
      end
      default: begin
        mem_wdata_valid = 1'b0;
      end
    endcase
  end

  // Detect a completed data beat in the current data phase.
  always_comb begin
    cntNextS = cntR + CNT_W'(1);
    case (stateR)
      WDATA:   beatS = mem_wdata_valid && mem_wdata_ready;
      RDATA:   beatS = mem_rdata_valid;
      default: beatS = 1'b0;
    endcase
  end

  // Arbitration FSM with registered command, status and error outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateR     <= IDLE;
      grantR     <= 2'd0;
      rnwR       <= 1'b0;
      addrR      <= {ADDR_W{1'b0}};
      cntR       <= {CNT_W{1'b0}};
      reqReadyR  <= 3'b000;
      cmdValidR  <= 1'b0;
      busyR      <= 1'b0;
      grantIdR   <= 2'd3;
      errR       <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      lastGrantR <= 2'd2;
`endif
    end else begin
      reqReadyR <= 3'b000;
      if (mem_rdata_valid && (stateR != RDATA)) begin
        errR <= 1'b1;
      end
      case (stateR)
        IDLE: begin
          if (|req_valid) begin
            grantR    <= winnerS;
            rnwR      <= winnerRnwS;
            addrR     <= winnerAddrS;
            reqReadyR <= toOneHot(winnerS);
            cmdValidR <= 1'b1;
            busyR     <= 1'b1;
            grantIdR  <= winnerS;
            stateR    <= CMD;
          end
        end
        CMD: begin
          if (mem_cmd_ready) begin
            cmdValidR <= 1'b0;
            cntR      <= {CNT_W{1'b0}};
            stateR    <= rnwR ? RDATA : WDATA;
          end
        end
        WDATA, RDATA: begin
          if (beatS) begin
            if (cntNextS == LAST_CNT) begin
              cntR     <= {CNT_W{1'b0}};
              busyR    <= 1'b0;
              grantIdR <= 2'd3;
              stateR   <= IDLE;
`ifndef ARB_FIXED_PRIO_EN
              lastGrantR <= grantR;
`endif
            end else begin
              cntR <= cntNextS;
            end
          end
        end
        default: begin
          stateR <= IDLE;
        end
      endcase
    end
  end

  assign req_ready       = reqReadyR;
  assign mem_cmd_valid   = cmdValidR;
  assign mem_cmd_rnw     = rnwR;
  assign mem_cmd_addr    = addrR;
  assign rd_data         = mem_rdata;
  assign busy            = busyR;
  assign grant_id        = grantIdR;
  assign err_unexp_rdata = errR;

endmodule
